// File: rtl/gppcu_alu_issue_pkg.sv
// Shared definitions for the GPPCU ALU issue/writeback sequencer:
// opcodes, condition codes, instruction field positions and FSM states.
package gppcu_alu_issue_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_MOV = 4'h1, OP_MVN = 4'h2, OP_ADC = 4'h3,
        OP_SBC = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_XOR = 4'h7,
        OP_ADI = 4'h8, OP_SBI = 4'h9, OP_MVI = 4'hA, OP_LSL = 4'hB,
        OP_LSR = 4'hC, OP_ASR = 4'hD, OP_UDE = 4'hE, OP_UDF = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        COND_AL = 2'b00, COND_ZS = 2'b01, COND_CS = 2'b10, COND_NS = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    localparam int F_OP_LSB   = 28;
    localparam int F_COND_LSB = 26;
    localparam int F_SETF     = 25;
    localparam int F_RD_LSB   = 21;
    localparam int F_RA_LSB   = 17;
    localparam int F_RB_LSB   = 13;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FL_N = 3;
    localparam int FL_Z = 2;
    localparam int FL_C = 1;

    localparam int RF_DEPTH = 16;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op == OP_UDE) || (op == OP_UDF);
    endfunction

    function automatic logic op_uses_imm(input logic [3:0] op);
        return (op == OP_ADI) || (op == OP_SBI) || (op == OP_MVI);
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return !((op == OP_NOP) || op_illegal(op));
    endfunction

endpackage

// File: rtl/gppcu_regfile.sv
// 16-entry register file: two asynchronous read ports, one write port and a
// registered debug read port that returns the pre-write value on a collision.
module gppcu_regfile
    import gppcu_alu_issue_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [3:0]    ra_addr_i,
    input  logic [3:0]    rb_addr_i,
    output logic [BW-1:0] ra_data_o,
    output logic [BW-1:0] rb_data_o,
    input  logic          we_i,
    input  logic [3:0]    waddr_i,
    input  logic [BW-1:0] wdata_i,
    input  logic [3:0]    dbg_addr_i,
    output logic [BW-1:0] dbg_data_o
);
    logic [BW-1:0] rf_q [RF_DEPTH];
    logic [BW-1:0] dbg_q;

    assign ra_data_o  = rf_q[ra_addr_i];
    assign rb_data_o  = rf_q[rb_addr_i];
    assign dbg_data_o = dbg_q;

    // Storage update and debug read capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            dbg_q <= '0;
        end else begin
            if (we_i) begin
                rf_q[waddr_i] <= wdata_i;
            end
            dbg_q <= rf_q[dbg_addr_i];
        end
    end

endmodule

// File: rtl/gppcu_alu_issue.sv
// Issue/writeback sequencer for the GPPCU ALU: accepts one instruction every
// three cycles, presents registered operands, and writes back result/flags.
module gppcu_alu_issue
    import gppcu_alu_issue_pkg::*;
#(
    parameter int BW   = 32,
    parameter int IMMW = 13
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iINSTR_VALID,
    input  logic [31:0]   iINSTR,
    output logic          oINSTR_READY,
    output logic [3:0]    oALU_OP,
    output logic [BW-1:0] oALU_A,
    output logic [BW-1:0] oALU_B,
    output logic          oALU_C,
    input  logic [BW-1:0] iALU_Q,
    input  logic          iALU_V,
    input  logic          iALU_C,
    input  logic          iALU_N,
    input  logic          iALU_Z,
    output logic [3:0]    oFLAGS,
    output logic          oDONE,
    output logic          oILLEGAL,
    output logic          oBUSY,
    input  logic [3:0]    iDBG_ADDR,
    output logic [BW-1:0] oDBG_DATA
);
    state_e        state_q, state_d;
    logic [3:0]    op_q;
    cond_e         cond_q;
    logic          setf_q;
    logic [3:0]    rd_q;
    logic [3:0]    alu_op_q;
    logic [BW-1:0] alu_a_q, alu_b_q;
    logic          alu_c_q;
    logic [3:0]    flags_q;
    logic          done_q, illegal_q;

    logic          accept_s, cond_pass_s, rf_we_s, flag_we_s;
    logic [3:0]    instr_op_s;
    logic [BW-1:0] ra_data_s, rb_data_s, imm_ext_s;

    assign instr_op_s = iINSTR[F_OP_LSB +: 4];
    assign imm_ext_s  = {{(BW-IMMW){iINSTR[IMMW-1]}}, iINSTR[IMMW-1:0]};

    gppcu_regfile #(.BW(BW)) u_regfile (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .ra_addr_i  (iINSTR[F_RA_LSB +: 4]),
        .rb_addr_i  (iINSTR[F_RB_LSB +: 4]),
        .ra_data_o  (ra_data_s),
        .rb_data_o  (rb_data_s),
        .we_i       (rf_we_s),
        .waddr_i    (rd_q),
        .wdata_i    (iALU_Q),
        .dbg_addr_i (iDBG_ADDR),
        .dbg_data_o (oDBG_DATA)
    );

    // Sequencer next state and accept strobe
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iINSTR_VALID) begin
                    accept_s = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Flags are only written in WB, so they still hold their accept-time value here
    always_comb begin
        cond_pass_s = 1'b0;
        case (cond_q)
            COND_AL: cond_pass_s = 1'b1;
            COND_ZS: cond_pass_s = flags_q[FL_Z];
            COND_CS: cond_pass_s = flags_q[FL_C];
            COND_NS: cond_pass_s = flags_q[FL_N];
            default: cond_pass_s = 1'b0;
        endcase
    end

    assign rf_we_s   = (state_q == ST_WB) && cond_pass_s && op_writes(op_q);
    assign flag_we_s = rf_we_s && setf_q;

    // State, latched instruction fields, ALU operand registers and flags
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            op_q      <= 4'h0;
            cond_q    <= COND_AL;
            setf_q    <= 1'b0;
            rd_q      <= 4'h0;
            alu_op_q  <= 4'h0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_c_q   <= 1'b0;
            flags_q   <= 4'h0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= (state_q == ST_ISSUE);
            illegal_q <= (state_q == ST_ISSUE) && op_illegal(op_q);
            if (accept_s) begin
                op_q     <= instr_op_s;
                cond_q   <= cond_e'(iINSTR[F_COND_LSB +: 2]);
                setf_q   <= iINSTR[F_SETF];
                rd_q     <= iINSTR[F_RD_LSB +: 4];
                alu_op_q <= op_illegal(instr_op_s) ? 4'h0 : instr_op_s;
                alu_a_q  <= ra_data_s;
                alu_b_q  <= op_uses_imm(instr_op_s) ? imm_ext_s : rb_data_s;
                alu_c_q  <= flags_q[FL_C];
            end
            if (flag_we_s) begin
                flags_q <= {iALU_N, iALU_Z, iALU_C, iALU_V};
            end
        end
    end

    assign oINSTR_READY = (state_q == ST_IDLE);
    assign oBUSY        = (state_q != ST_IDLE);
    assign oALU_OP      = alu_op_q;
    assign oALU_A       = alu_a_q;
    assign oALU_B       = alu_b_q;
    assign oALU_C       = alu_c_q;
    assign oFLAGS       = flags_q;
    assign oDONE        = done_q;
    assign oILLEGAL     = illegal_q;

endmodule

// File: tb/tb_gppcu_alu_issue.sv
// Self-checking bench for gppcu_alu_issue: a stand-in ALU drives the result
// ports and an instruction-level reference model predicts RF, flags and outputs.
module tb_gppcu_alu_issue;
    localparam int BW = 32;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iINSTR_VALID;
    logic [31:0]   iINSTR;
    logic          oINSTR_READY;
    logic [3:0]    oALU_OP;
    logic [BW-1:0] oALU_A, oALU_B;
    logic          oALU_C;
    logic [BW-1:0] iALU_Q;
    logic          iALU_V, iALU_C, iALU_N, iALU_Z;
    logic [3:0]    oFLAGS;
    logic          oDONE, oILLEGAL, oBUSY;
    logic [3:0]    iDBG_ADDR;
    logic [BW-1:0] oDBG_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [BW-1:0] m_rf [16];
    logic [3:0]    m_fl;

    gppcu_alu_issue #(.BW(BW), .IMMW(13)) dut (
        .iCLK(iCLK), .iRST(iRST), .iINSTR_VALID(iINSTR_VALID), .iINSTR(iINSTR),
        .oINSTR_READY(oINSTR_READY), .oALU_OP(oALU_OP), .oALU_A(oALU_A),
        .oALU_B(oALU_B), .oALU_C(oALU_C), .iALU_Q(iALU_Q), .iALU_V(iALU_V),
        .iALU_C(iALU_C), .iALU_N(iALU_N), .iALU_Z(iALU_Z), .oFLAGS(oFLAGS),
        .oDONE(oDONE), .oILLEGAL(oILLEGAL), .oBUSY(oBUSY),
        .iDBG_ADDR(iDBG_ADDR), .oDBG_DATA(oDBG_DATA)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc++;
    always @(negedge iCLK) if (oDONE === 1'b1) done_cnt++;

    // Stand-in ALU: returns {N,Z,C,V,Q}
    function automatic logic [BW+3:0] alu_ref(input logic [3:0] op, input logic [BW-1:0] a,
                                              input logic [BW-1:0] b, input logic c);
        logic [BW:0]   s;
        logic [BW-1:0] q;
        logic          co, v;
        s = '0; q = '0; co = 1'b0; v = 1'b0;
        case (op)
            4'h1: q = a;
            4'h2: q = ~a;
            4'h3, 4'h8: begin
                s  = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, (op == 4'h3) ? c : 1'b0};
                q  = s[BW-1:0]; co = s[BW];
                v  = (a[BW-1] == b[BW-1]) && (q[BW-1] != a[BW-1]);
            end
            4'h4, 4'h9: begin
                s  = {1'b0, a} + {1'b0, ~b} + {{BW{1'b0}}, (op == 4'h4) ? c : 1'b1};
                q  = s[BW-1:0]; co = s[BW];
                v  = (a[BW-1] != b[BW-1]) && (q[BW-1] != a[BW-1]);
            end
            4'h5: q = a & b;
            4'h6: q = a | b;
            4'h7: q = a ^ b;
            4'hA: q = b;
            4'hB: q = a << b[4:0];
            4'hC: q = a >> b[4:0];
            4'hD: q = $unsigned($signed(a) >>> b[4:0]);
            default: q = '0;
        endcase
        return {q[BW-1], (q == '0), co, v, q};
    endfunction

    assign {iALU_N, iALU_Z, iALU_C, iALU_V, iALU_Q} = alu_ref(oALU_OP, oALU_A, oALU_B, oALU_C);

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] cond, input logic setf,
                                       input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [12:0] imm);
        return {op, cond, setf, rd, ra, rb, imm};
    endfunction

    function automatic logic cond_ok(input logic [1:0] cond, input logic [3:0] fl);
        case (cond)
            2'b00:   return 1'b1;
            2'b01:   return fl[2];
            2'b10:   return fl[1];
            default: return fl[3];
        endcase
    endfunction

    // Architectural operands an instruction should see: {op_to_alu, A, B, Cin}
    task automatic operands(input logic [31:0] w, output logic [3:0] aop, output logic [BW-1:0] a,
                            output logic [BW-1:0] b, output logic c);
        logic [3:0] op;
        op  = w[31:28];
        aop = (op >= 4'hE) ? 4'h0 : op;
        a   = m_rf[w[20:17]];
        b   = (op == 4'h8 || op == 4'h9 || op == 4'hA) ? {{(BW-13){w[12]}}, w[12:0]} : m_rf[w[16:13]];
        c   = m_fl[1];
    endtask

    task automatic model_exec(input logic [31:0] w);
        logic [3:0]    aop, op;
        logic [BW-1:0] a, b;
        logic          c;
        logic [BW+3:0] r;
        op = w[31:28];
        operands(w, aop, a, b, c);
        r = alu_ref(aop, a, b, c);
        if (cond_ok(w[27:26], m_fl) && op != 4'h0 && op < 4'hE) begin
            m_rf[w[24:21]] = r[BW-1:0];
            if (w[25]) m_fl = r[BW+3:BW];
        end
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (oINSTR_READY !== 1'b1 && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        if (oINSTR_READY !== 1'b1) chk("ready_timeout", {31'd0, oINSTR_READY}, 32'd1);
    endtask

    task automatic check_reg(input logic [3:0] r);
        @(negedge iCLK);
        iDBG_ADDR = r;
        @(posedge iCLK); #1;
        chk("dbg_rf", oDBG_DATA, m_rf[r]);
    endtask

    // One instruction end to end, checking every phase
    task automatic do_instr(input logic [31:0] w);
        logic [3:0]    aop;
        logic [BW-1:0] a, b, old;
        logic          c;
        @(negedge iCLK);
        iINSTR_VALID = 1'b1;
        iINSTR = w;
        wait_ready();
        operands(w, aop, a, b, c);
        @(posedge iCLK); #1;
        iINSTR_VALID = 1'b0;
        iDBG_ADDR = w[24:21];
        chk("issue_op", {28'd0, oALU_OP}, {28'd0, aop});
        chk("issue_a", oALU_A, a);
        chk("issue_b", oALU_B, b);
        chk("issue_c", {31'd0, oALU_C}, {31'd0, c});
        chk("issue_ready", {31'd0, oINSTR_READY}, 32'd0);
        chk("issue_busy", {31'd0, oBUSY}, 32'd1);
        @(posedge iCLK); #1;
        chk("wb_done", {31'd0, oDONE}, 32'd1);
        chk("wb_illegal", {31'd0, oILLEGAL}, {31'd0, (w[31:28] >= 4'hE)});
        old = m_rf[w[24:21]];
        model_exec(w);
        @(posedge iCLK); #1;
        chk("idle_ready", {31'd0, oINSTR_READY}, 32'd1);
        chk("idle_done", {31'd0, oDONE}, 32'd0);
        chk("idle_flags", {28'd0, oFLAGS}, {28'd0, m_fl});
        chk("hold_a", oALU_A, a);
        chk("dbg_old", oDBG_DATA, old);
        @(posedge iCLK); #1;
        chk("dbg_new", oDBG_DATA, m_rf[w[24:21]]);
    endtask

    logic [31:0] w;
    logic [31:0] w4 [4];
    int          t4 [4];
    int          d0;

    initial begin
        iRST = 1'b1; iINSTR_VALID = 1'b0; iINSTR = 32'd0; iDBG_ADDR = 4'd0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_fl = 4'h0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_ready", {31'd0, oINSTR_READY}, 32'd1);
        chk("rst_busy", {31'd0, oBUSY}, 32'd0);
        chk("rst_done", {31'd0, oDONE}, 32'd0);
        chk("rst_ill", {31'd0, oILLEGAL}, 32'd0);
        chk("rst_flags", {28'd0, oFLAGS}, 32'd0);
        chk("rst_aluop", {28'd0, oALU_OP}, 32'd0);
        chk("rst_alua", oALU_A, 32'd0);
        chk("rst_alub", oALU_B, 32'd0);
        chk("rst_dbg", oDBG_DATA, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        // Directed sequence from the test plan
        do_instr(mk(4'hA, 2'b00, 1'b0, 4'd1, 4'd0, 4'd0, 13'h1FFF));
        chk("mvi_neg1", m_rf[1], 32'hFFFF_FFFF);
        do_instr(mk(4'hA, 2'b00, 1'b0, 4'd2, 4'd0, 4'd0, 13'd5));
        do_instr(mk(4'hA, 2'b00, 1'b0, 4'd3, 4'd0, 4'd0, 13'd7));
        do_instr(mk(4'h3, 2'b00, 1'b1, 4'd4, 4'd2, 4'd3, 13'd0));
        chk("adc_12", m_rf[4], 32'd12);
        do_instr(mk(4'h9, 2'b00, 1'b1, 4'd5, 4'd2, 4'd0, 13'd5));
        do_instr(mk(4'hA, 2'b01, 1'b0, 4'd6, 4'd0, 4'd0, 13'd9));
        chk("cond_pass", m_rf[6], 32'd9);
        do_instr(mk(4'h8, 2'b00, 1'b1, 4'd8, 4'd2, 4'd0, 13'd1));
        do_instr(mk(4'hA, 2'b01, 1'b0, 4'd6, 4'd0, 4'd0, 13'h44));
        do_instr(mk(4'hE, 2'b00, 1'b1, 4'd6, 4'd2, 4'd3, 13'd1));
        do_instr(mk(4'hF, 2'b00, 1'b1, 4'd4, 4'd4, 4'd4, 13'd3));

        // VALID held: accepts every third cycle, none lost or duplicated
        w4[0] = mk(4'hA, 2'b00, 1'b0, 4'd9,  4'd0, 4'd0, 13'd100);
        w4[1] = mk(4'h8, 2'b00, 1'b1, 4'd10, 4'd9, 4'd0, 13'h1FFE);
        w4[2] = mk(4'h7, 2'b00, 1'b0, 4'd11, 4'd9, 4'd10, 13'd0);
        w4[3] = mk(4'hB, 2'b00, 1'b0, 4'd12, 4'd11, 4'd0, 13'd0);
        d0 = done_cnt;
        @(negedge iCLK);
        iINSTR_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iINSTR = w4[k];
            wait_ready();
            t4[k] = cyc;
            model_exec(w4[k]);
            @(negedge iCLK);
        end
        iINSTR_VALID = 1'b0;
        repeat (4) @(negedge iCLK);
        for (int k = 0; k < 3; k++) chk("b2b_spacing", t4[k+1] - t4[k], 32'd3);
        chk("b2b_done_cnt", done_cnt - d0, 32'd4);
        for (int r = 9; r <= 12; r++) check_reg(4'(r));

        // Randomized instructions against the reference model
        for (int i = 0; i < 60; i++) begin
            w = mk(4'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 13'($urandom));
            do_instr(w);
        end
        for (int r = 0; r < 16; r++) check_reg(4'(r));

        // Reset during ISSUE abandons the instruction and clears the RF
        do_instr(mk(4'hA, 2'b00, 1'b0, 4'd7, 4'd0, 4'd0, 13'h55));
        @(negedge iCLK);
        iINSTR_VALID = 1'b1;
        iINSTR = mk(4'hA, 2'b00, 1'b0, 4'd7, 4'd0, 4'd0, 13'd3);
        wait_ready();
        @(posedge iCLK); #1;
        iINSTR_VALID = 1'b0;
        iRST = 1'b1;
        d0 = done_cnt;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_fl = 4'h0;
        chk("mrst_ready", {31'd0, oINSTR_READY}, 32'd1);
        chk("mrst_busy", {31'd0, oBUSY}, 32'd0);
        chk("mrst_flags", {28'd0, oFLAGS}, 32'd0);
        @(posedge iCLK); #1;
        chk("mrst_done", {31'd0, oDONE}, 32'd0);
        repeat (3) @(negedge iCLK);
        chk("mrst_done_cnt", done_cnt - d0, 32'd0);
        for (int r = 0; r < 16; r++) check_reg(4'(r));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
